branch_hazard_scoreboard: RTL

- Sequential hazard controller for the fetch stage of the RV32I pipeline.
- Keeps a per-register scoreboard of in-flight destination writes, each with a countdown to result availability.
- Raises stall for:
  - branch/JALR RAW hazards, which the early branch-compare logic cannot resolve through forwarding;
  - load-use hazards for all other consumers.
- Sits beside the fetch/decode boundary. Drives the fetch hold and the decode bubble insert.

---
 rtl/branch_hazard_scoreboard.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/branch_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : branch_hazard_scoreboard
//  Description : Fetch-stage hazard controller for an RV32I pipeline. Tracks
//                in-flight register writes with a per-register countdown to
//                result availability and holds fetch (inserting a decode
//                bubble) on branch/JALR RAW hazards and one-bubble load-use
//                hazards.
//
//  Ports
//    clk             in   core clock
//    rst             in   asynchronous active-high reset
//    fetch_valid     in   fetch holds a valid instruction
//    fetch_instr     in   instruction in fetch (rs1 [19:15], rs2 [24:20],
//                         rd [11:7], opcode [6:0])
//    fetch_reg_write in   fetch instruction writes rd
//    flush           in   squash the fetch instruction this cycle
//    stall           out  hold fetch, insert bubble into decode
//    issue_fire      out  fetch instruction advances this cycle
//    busy_vec        out  scoreboard busy bits (bit 0 always 0)
//    stall_count     out  saturating count of stalled cycles
//
//  Revision    : 1.0  initial release
// ============================================================================
module branch_hazard_scoreboard #(
    parameter int ALU_LAT  = 2,   // issue-to-comparator latency, non-load (1..7)
    parameter int LOAD_LAT = 3,   // issue-to-comparator latency, load (2..7)
    parameter int CNT_W    = 16   // stall counter width
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fetch_valid,
    input  logic [31:0]      fetch_instr,
    input  logic             fetch_reg_write,
    input  logic             flush,
    output logic             stall,
    output logic             issue_fire,
    output logic [31:0]      busy_vec,
    output logic [CNT_W-1:0] stall_count
);

    // ------------------------------------------------------------------------
    // Opcode constants (RV32I base major opcodes)
    // ------------------------------------------------------------------------
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [2:0] ALU_LAT_V  = 3'(ALU_LAT);
    localparam logic [2:0] LOAD_LAT_V = 3'(LOAD_LAT);

    // ------------------------------------------------------------------------
    // Scoreboard state
    // ------------------------------------------------------------------------
    logic [2:0]       cnt_q     [32];
    logic [2:0]       cnt_d     [32];
    logic [31:0]      is_load_q;
    logic [31:0]      is_load_d;
    logic [CNT_W-1:0] stall_count_q;
    logic [CNT_W-1:0] stall_count_d;

    // ------------------------------------------------------------------------
    // Fetch instruction field extraction and source-usage decode
    // ------------------------------------------------------------------------
    logic [6:0] w_opcode;
    logic [4:0] w_rs1;
    logic [4:0] w_rs2;
    logic [4:0] w_rd;
    logic       w_use_rs1;
    logic       w_use_rs2;
    logic       w_is_branch;   // BRANCH or JALR: resolved by early compare
    logic       w_is_load;

    assign w_opcode  = fetch_instr[6:0];
    assign w_rd      = fetch_instr[11:7];
    assign w_rs1     = fetch_instr[19:15];
    assign w_rs2     = fetch_instr[24:20];
    assign w_is_load = (w_opcode == OPC_LOAD);

    always_comb begin
        w_use_rs1   = 1'b0;
        w_use_rs2   = 1'b0;
        w_is_branch = 1'b0;
        case (w_opcode)
            OPC_BRANCH: begin
                w_use_rs1   = 1'b1;
                w_use_rs2   = 1'b1;
                w_is_branch = 1'b1;
            end
            OPC_JALR: begin
                w_use_rs1   = 1'b1;
                w_is_branch = 1'b1;
            end
            OPC_LUI, OPC_AUIPC, OPC_JAL: begin
                w_use_rs1 = 1'b0;
                w_use_rs2 = 1'b0;
            end
            OPC_LOAD, OPC_OP_IMM, OPC_SYSTEM, OPC_FENCE: begin
                w_use_rs1 = 1'b1;
            end
            OPC_STORE, OPC_OP: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
            end
            // Unrecognised encodings are treated conservatively as reading
            // both source fields.
            default: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Hazard detection (pre-update state only, so an instruction whose rd
    // equals one of its sources never sees its own write).
    //
    // Branches compare in fetch and cannot use forwarding, so any pending
    // write blocks them. Other consumers get forwarding from EX/MEM and only
    // need a bubble when the producer is a load issued the previous cycle,
    // which is exactly the state where its counter still equals LOAD_LAT.
    // ------------------------------------------------------------------------
    logic w_haz_rs1;
    logic w_haz_rs2;
    logic w_any_haz;
    logic w_fetch_live;

    always_comb begin
        w_haz_rs1 = 1'b0;
        w_haz_rs2 = 1'b0;
        if (w_use_rs1 && (w_rs1 != 5'd0)) begin
            if (w_is_branch) begin
                w_haz_rs1 = (cnt_q[w_rs1] != 3'd0);
            end else begin
                w_haz_rs1 = is_load_q[w_rs1] && (cnt_q[w_rs1] == LOAD_LAT_V);
            end
        end
        if (w_use_rs2 && (w_rs2 != 5'd0)) begin
            if (w_is_branch) begin
                w_haz_rs2 = (cnt_q[w_rs2] != 3'd0);
            end else begin
                w_haz_rs2 = is_load_q[w_rs2] && (cnt_q[w_rs2] == LOAD_LAT_V);
            end
        end
    end

    assign w_any_haz    = w_haz_rs1 | w_haz_rs2;
    // rst gating keeps both handshake outputs low for the whole reset window,
    // even if fetch presents a valid instruction.
    assign w_fetch_live = ~rst & fetch_valid & ~flush;
    assign stall        = w_fetch_live & w_any_haz;
    assign issue_fire   = w_fetch_live & ~w_any_haz;

    // ------------------------------------------------------------------------
    // Next-state for counters. A new issue to r takes priority over the
    // expiring countdown of r (WAW: newest writer wins). is_load is cleared
    // together with the counter reaching zero so a stale load flag can never
    // alias with a later ALU write.
    // ------------------------------------------------------------------------
    logic w_issue_write;

    assign w_issue_write = issue_fire & fetch_reg_write;

    always_comb begin
        for (int r = 0; r < 32; r++) begin
            cnt_d[r]     = cnt_q[r];
            is_load_d[r] = is_load_q[r];
            if (r == 0) begin
                cnt_d[r]     = 3'd0;
                is_load_d[r] = 1'b0;
            end else if (w_issue_write && (w_rd == 5'(r))) begin
                cnt_d[r]     = w_is_load ? LOAD_LAT_V : ALU_LAT_V;
                is_load_d[r] = w_is_load;
            end else if (cnt_q[r] != 3'd0) begin
                cnt_d[r] = cnt_q[r] - 3'd1;
                if (cnt_q[r] == 3'd1) begin
                    is_load_d[r] = 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Saturating stall performance counter
    // ------------------------------------------------------------------------
    always_comb begin
        stall_count_d = stall_count_q;
        if (stall && !(&stall_count_q)) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < 32; r++) begin
                cnt_q[r] <= 3'd0;
            end
            is_load_q     <= 32'd0;
            stall_count_q <= '0;
        end else begin
            for (int r = 0; r < 32; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            is_load_q     <= is_load_d;
            stall_count_q <= stall_count_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs derived from registered state
    // ------------------------------------------------------------------------
    always_comb begin
        busy_vec = 32'd0;
        for (int r = 1; r < 32; r++) begin
            busy_vec[r] = (cnt_q[r] != 3'd0);
        end
    end

    assign stall_count = stall_count_q;

endmodule
`default_nettype wire
